// File: rtl/hamming_fsk_tx.sv
// Hamming(11,7) encoder and MSB-first serialiser feeding FSKEncoder.
// Optional single-bit error injection is enabled by defining HAMMING_ERR_INJECT_EN.
module hamming_fsk_tx #(
  parameter int unsigned BIT_CYCLES = 16,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        quickclk,
  input  logic        reset,
  input  logic [6:0]  data_in,
  input  logic        data_valid,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic        err_en,
  input  logic [3:0]  err_pos,
`endif
  output logic        data_ready,
  output logic        codeout,
  output logic        sending,
  output logic        frame_done,
  output logic [10:0] codeword
);

  localparam int unsigned CYC_W = $clog2(BIT_CYCLES + 1);
  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [10:0]      sr_q, sr_d;
  logic [3:0]       bit_q, bit_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             ready_q, ready_d;
  logic             codeout_q, codeout_d;
  logic             sending_q, sending_d;
  logic             done_q, done_d;
  logic [10:0]      cw_q, cw_d;
  logic [10:0]      enc;

  // Encoder: data at non-power-of-two positions, even parity at 1,2,4,8.
  always_comb begin
    enc     = '0;
    enc[2]  = data_in[0];
    enc[4]  = data_in[1];
    enc[5]  = data_in[2];
    enc[6]  = data_in[3];
    enc[8]  = data_in[4];
    enc[9]  = data_in[5];
    enc[10] = data_in[6];
    enc[0]  = data_in[0] ^ data_in[1] ^ data_in[3] ^ data_in[4] ^ data_in[6];
    enc[1]  = data_in[0] ^ data_in[2] ^ data_in[3] ^ data_in[5] ^ data_in[6];
    enc[3]  = data_in[1] ^ data_in[2] ^ data_in[3];
    enc[7]  = data_in[4] ^ data_in[5] ^ data_in[6];
`ifdef HAMMING_ERR_INJECT_EN
    for (int i = 0; i < 11; i++) begin
      if (err_en && (err_pos == 4'(i + 1))) enc[i] = ~enc[i];
    end
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_d     = bit_q;
    cyc_d     = cyc_q;
    gap_d     = gap_q;
    ready_d   = ready_q;
    codeout_d = codeout_q;
    sending_d = sending_q;
    cw_d      = cw_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (data_valid && ready_q) begin
          state_d   = S_SEND;
          sr_d      = enc;
          cw_d      = enc;
          bit_d     = 4'd10;
          cyc_d     = '0;
          sending_d = 1'b1;
          codeout_d = enc[10];
          ready_d   = 1'b0;
        end
      end
      S_SEND: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (bit_q == 4'd0) begin
            sending_d = 1'b0;
            codeout_d = 1'b0;
            if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
              gap_d   = '0;
              ready_d = 1'b0;
            end else begin
              state_d = S_IDLE;
              ready_d = 1'b1;
            end
          end else begin
            // Rotate so the next lower bit sits at [10]; [9] is that bit now.
            bit_d     = bit_q - 4'd1;
            sr_d      = {sr_q[9:0], sr_q[10]};
            codeout_d = sr_q[9];
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
          gap_d   = '0;
          ready_d = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        ready_d   = 1'b1;
        sending_d = 1'b0;
        codeout_d = 1'b0;
      end
    endcase

    // Flag the final cycle of c[0] one edge ahead so the pulse is registered.
    if ((state_d == S_SEND) && (bit_d == 4'd0) && (cyc_d == CYC_LAST)) done_d = 1'b1;
  end

  always_ff @(posedge quickclk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sr_q      <= '0;
      bit_q     <= '0;
      cyc_q     <= '0;
      gap_q     <= '0;
      ready_q   <= 1'b1;
      codeout_q <= 1'b0;
      sending_q <= 1'b0;
      done_q    <= 1'b0;
      cw_q      <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_q     <= bit_d;
      cyc_q     <= cyc_d;
      gap_q     <= gap_d;
      ready_q   <= ready_d;
      codeout_q <= codeout_d;
      sending_q <= sending_d;
      done_q    <= done_d;
      cw_q      <= cw_d;
    end
  end

  assign data_ready = ready_q;
  assign codeout    = codeout_q;
  assign sending    = sending_q;
  assign frame_done = done_q;
  assign codeword   = cw_q;

endmodule

// File: tb/tb_hamming_fsk_tx.sv
// Bench for hamming_fsk_tx: a default instance (16/4) and a fast instance (1/0),
// each checked every cycle against a frame-timeline model, plus directed literals.
module tb_hamming_fsk_tx;
  localparam int B0 = 16, G0 = 4, B1 = 1, G1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, v0, rst1, v1;
  logic [6:0] d0, d1;
  logic r0, co0, s0, fd0, r1, co1, s1, fd1;
  logic [10:0] cw0, cw1;
  logic ee0 = 1'b0, ee1 = 1'b0;
  logic [3:0] ep0 = 4'd0, ep1 = 4'd0;

  hamming_fsk_tx #(.BIT_CYCLES(B0), .GAP_CYCLES(G0)) u0 (
    .quickclk(clk), .reset(rst0), .data_in(d0), .data_valid(v0),
`ifdef HAMMING_ERR_INJECT_EN
    .err_en(ee0), .err_pos(ep0),
`endif
    .data_ready(r0), .codeout(co0), .sending(s0), .frame_done(fd0), .codeword(cw0));

  hamming_fsk_tx #(.BIT_CYCLES(B1), .GAP_CYCLES(G1)) u1 (
    .quickclk(clk), .reset(rst1), .data_in(d1), .data_valid(v1),
`ifdef HAMMING_ERR_INJECT_EN
    .err_en(ee1), .err_pos(ep1),
`endif
    .data_ready(r1), .codeout(co1), .sending(s1), .frame_done(fd1), .codeword(cw1));

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Generic Hamming construction: data fills non-power-of-two positions in order,
  // parity at position p covers every other position whose index has bit p set.
  function automatic logic [10:0] enc(logic [6:0] d);
    logic [10:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 1; p <= 11; p++)
      if ((p & (p - 1)) != 0) begin c[p-1] = d[k]; k++; end
    for (int p = 1; p <= 11; p++)
      if ((p & (p - 1)) == 0)
        for (int q = 1; q <= 11; q++)
          if (q != p && (q & p) != 0) c[p-1] = c[p-1] ^ c[q-1];
    return c;
  endfunction

  function automatic logic [6:0] dec(logic [10:0] cin);
    logic [10:0] c;
    logic [6:0] d;
    int s, k;
    c = cin;
    s = 0;
    k = 0;
    d = '0;
    for (int p = 1; p <= 11; p++) if (c[p-1]) s = s ^ p;
    if (s >= 1 && s <= 11) c[s-1] = ~c[s-1];
    for (int p = 1; p <= 11; p++)
      if ((p & (p - 1)) != 0) begin d[k] = c[p-1]; k++; end
    return d;
  endfunction

  function automatic logic [10:0] inject(logic [10:0] c, logic en, logic [3:0] pos);
    logic [10:0] r;
    r = c;
`ifdef HAMMING_ERR_INJECT_EN
    if (en && pos >= 4'd1 && pos <= 4'd11) r[pos-1] = ~r[pos-1];
`else
    if (en && pos == 4'd15) r = c;
`endif
    return r;
  endfunction

  // Model: each instance is idle, or at a cycle offset since the accepting edge.
  bit          m_idle[2] = '{1'b1, 1'b1};
  int          m_pos[2]  = '{0, 0};
  logic [10:0] m_cw[2]   = '{11'h0, 11'h0};
  logic [6:0]  pq1[$];

  task automatic step(int k, int B, int G, logic rst, logic v, logic [6:0] d, logic e, logic [3:0] ep);
    if (rst) begin
      m_idle[k] = 1'b1; m_pos[k] = 0; m_cw[k] = '0;
    end else if (m_idle[k]) begin
      if (v) begin
        m_idle[k] = 1'b0; m_pos[k] = 0; m_cw[k] = inject(enc(d), e, ep);
        if (k == 1) pq1.push_back(d);
      end
    end else begin
      m_pos[k]++;
      if (m_pos[k] >= 11 * B + G) m_idle[k] = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    step(0, B0, G0, rst0, v0, d0, ee0, ep0);
    step(1, B1, G1, rst1, v1, d1, ee1, ep1);
  end

  task automatic cmp(int k, int B, logic r, logic co, logic s, logic fd, logic [10:0] cw);
    logic er, ec, es, ef;
    er = 1'b0; ec = 1'b0; es = 1'b0; ef = 1'b0;
    if (m_idle[k]) er = 1'b1;
    else if (m_pos[k] < 11 * B) begin
      es = 1'b1;
      ec = m_cw[k][10 - m_pos[k] / B];
      ef = (m_pos[k] == 11 * B - 1);
    end
    chk($sformatf("ready%0d", k), r, er);
    chk($sformatf("sending%0d", k), s, es);
    chk($sformatf("codeout%0d", k), co, ec);
    chk($sformatf("frame_done%0d", k), fd, ef);
    chk($sformatf("codeword%0d", k), cw, m_cw[k]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, B0, r0, co0, s0, fd0, cw0);
      cmp(1, B1, r1, co1, s1, fd1, cw1);
    end
  end

  // Loopback: reassemble serial frames from the fast instance and decode them.
  logic [10:0] sh = '0;
  int nbits = 0, ndec = 0;
  always @(negedge clk) begin
    if (chk_en && s1) begin
      sh = {sh[9:0], co1};
      nbits++;
      if (nbits == 11) begin
        nbits = 0;
        ndec++;
        if (pq1.size() == 0) chk("loopback_queue", 0, 1);
        else chk("loopback", dec(sh), pq1.pop_front());
      end
    end
  end

  // Run-length monitor for continuous-valid traffic on the fast instance.
  bit mon1 = 1'b0, prev1 = 1'b0, seen_hi = 1'b0;
  int hi1 = 0, lo1 = 0;
  always @(negedge clk) begin
    if (mon1) begin
      if (s1) begin
        if (!prev1) begin
          if (seen_hi) chk("gap1_len", lo1, 1);
          hi1 = 0;
        end
        hi1++;
      end else begin
        if (prev1) begin
          chk("frame1_len", hi1, 11);
          seen_hi = 1'b1;
          lo1 = 0;
        end
        lo1++;
      end
      prev1 = s1;
    end
  end

  task automatic wait_ready(int k, int limit, string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if ((k == 0) ? r0 : r1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk(nm, 0, 1);
  endtask

  task automatic send0(logic [6:0] d);
    d0 = d; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
  endtask

  // Called on the first sending cycle; walks the whole frame on instance 0.
  task automatic measure0(logic [10:0] exp_cw, string nm);
    int hi, fdat;
    hi = 0; fdat = -1;
    chk({nm, "_busy_ready"}, r0, 0);
    while (s0 && hi < 400) begin
      hi++;
      if (fd0) fdat = hi;
      if ((hi - 1) % 16 == 8) chk({nm, "_bit"}, co0, exp_cw[10 - (hi - 1) / 16]);
      @(negedge clk);
    end
    chk({nm, "_len"}, hi, 176);
    chk({nm, "_fd_at"}, fdat, 176);
    chk({nm, "_cw"}, cw0, exp_cw);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int lo;
    rst0 = 1'b1; rst1 = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_ready", r0, 1);
    chk("rst_sending", s0, 0);
    chk("rst_codeout", co0, 0);
    chk("rst_codeword", cw0, 0);
    chk("enc55", enc(7'h55), 11'h52F);
    chk("enc7f", enc(7'h7F), 11'h7FF);
    chk("dec52f", dec(11'h52F), 7'h55);
    rst0 = 1'b0; rst1 = 1'b0;

    send0(7'h55);
    measure0(11'h52F, "f55");

    d0 = 7'h2A;
    wait_ready(0, 20, "ready_after_gap");
    d0 = 7'h00; v0 = 1'b1;
    @(negedge clk);
    d0 = 7'h7F;
    measure0(11'h000, "f00");
    lo = 0;
    while (!s0 && lo < 50) begin lo++; @(negedge clk); end
    chk("b2b_gap", lo, 5);
    v0 = 1'b0;
    measure0(11'h7FF, "f7f");

    wait_ready(0, 20, "ready_before_abort");
    send0(7'h55);
    repeat (85) @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    chk("abort_sending", s0, 0);
    chk("abort_codeout", co0, 0);
    chk("abort_ready", r0, 1);
    rst0 = 1'b0;
    send0(7'h55);
    measure0(11'h52F, "frestart");

`ifdef HAMMING_ERR_INJECT_EN
    wait_ready(0, 20, "ready_before_inject");
    ee0 = 1'b1; ep0 = 4'd6;
    send0(7'h55);
    ee0 = 1'b0; ep0 = 4'd0;
    measure0(11'h50F, "finj");
    chk("inj_decode", dec(cw0), 7'h55);
`endif

    mon1 = 1'b1;
    v1 = 1'b1;
    for (int w = 0; w < 128; w++) begin
      d1 = 7'(w);
      wait_ready(1, 40, "ready1");
      @(negedge clk);
    end
    v1 = 1'b0;
    wait_ready(1, 40, "ready1_end");
    @(negedge clk);
    mon1 = 1'b0;
    chk("loopback_count", ndec, 128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hamming_fsk_tx.md
Name: hamming_fsk_tx

Overview:
- Transmit-side framer for the Hamming/FSK link.
- Accepts 7-bit payload words over a valid/ready handshake and Hamming(11,7)-encodes each one.
- Serialises the 11-bit codeword MSB first, each bit held for BIT_CYCLES quickclk cycles.
- Drives codeout/sending straight into FSKEncoder. It is the inverse of the DecodeProcessor + HammingDecoder receive path, so HammingDecoder recovers the original 7 bits.

Parameters:
- BIT_CYCLES, 16, quickclk cycles per transmitted bit; must be >= 1.
- GAP_CYCLES, 4, idle quickclk cycles with sending=0 between frames; 0 is legal.

Ports:
- quickclk input 1: system clock, rising edge.
- reset input 1: synchronous, active-high reset.
- data_in input 7: payload word d[6:0].
- data_valid input 1: payload present.
- data_ready output 1: block can accept a payload this cycle.
- codeout output 1: serial codeword bit to FSKEncoder.
- sending output 1: high for exactly 11*BIT_CYCLES cycles per frame.
- frame_done output 1: one-cycle pulse on the last cycle of the last bit.
- codeword output 11: registered copy of the codeword in flight, for monitoring.

Behaviour:
- Reset, sampled on the quickclk edge: state=IDLE, data_ready=1, codeout=0, sending=0, frame_done=0, codeword=0, counters=0.
- Encoding: codeword bit c[i] is Hamming position i+1.
  - Data placement: c[2]=d0, c[4]=d1, c[5]=d2, c[6]=d3, c[8]=d4, c[9]=d5, c[10]=d6.
  - Parity (even): c[0]=d0^d1^d3^d4^d6, c[1]=d0^d2^d3^d5^d6, c[3]=d1^d2^d3, c[7]=d4^d5^d6.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - data_ready=1.
  - On data_valid&&data_ready: latch the encoded word into a shift register and the codeword output, go to SEND.
  - On that same edge: sending=1, codeout=c[10], data_ready=0.
  - data_in is ignored when data_valid=0.
- SEND:
  - bit_cnt counts 10 down to 0; cyc_cnt counts 0 to BIT_CYCLES-1.
  - When cyc_cnt wraps, advance to the next lower bit. Bit order on the line is c[10], c[9], ..., c[0].
  - frame_done=1 on the final cycle of c[0].
  - On the next edge: sending=0, codeout=0. Go to GAP if GAP_CYCLES>0, otherwise go to IDLE.
- GAP:
  - Count GAP_CYCLES cycles with data_ready=0, then go to IDLE.
- Handshake:
  - data_ready depends only on state, never combinationally on data_valid.
  - A payload held valid during SEND or GAP is accepted on the first IDLE cycle.
  - With data_valid held high, back-to-back frames are separated by exactly GAP_CYCLES+1 cycles of sending=0: GAP_CYCLES in GAP plus one IDLE accept cycle.
- Latency: sending rises 1 cycle after the accepting edge. A frame occupies exactly 11*BIT_CYCLES cycles.
- BIT_CYCLES=1: one bit per cycle, with no idle cycle inside the frame.
- Counter widths: $clog2(BIT_CYCLES+1) for cyc_cnt and $clog2(GAP_CYCLES+1) for the gap counter (minimum 1). Counters never overflow or wrap beyond their terminal values.
- Reset mid-frame or mid-gap: the frame is abandoned, all outputs return to reset values on that edge, and the partial frame is not resumed.
- data_in changing after acceptance has no effect on the frame in flight.

Optional Feature:
- Macro HAMMING_ERR_INJECT_EN.
- When defined:
  - Adds inputs err_en (1) and err_pos (4).
  - If err_en=1 at acceptance, codeword bit c[err_pos-1] is inverted after encoding, for err_pos 1..11.
  - err_pos of 0 or 12..15 injects nothing.
  - The codeword output shows the corrupted word.
  - Used to prove single-bit correction in HammingDecoder.
- When undefined: these ports do not exist and the codeword is always clean.

Test Plan:
- Reset, then data_in=7'h55 with valid pulsed → codeword=11'h52F. codeout sequence 1,0,1,0,0,1,0,1,1,1,1, each bit 16 cycles. sending high for 176 cycles. frame_done on cycle 176.
- data_in=7'h00 then 7'h7F with data_valid held high → codewords 11'h000 then 11'h7FF. Exactly 5 sending=0 cycles between frames. data_ready=0 throughout SEND and GAP.
- BIT_CYCLES=1, GAP_CYCLES=0, continuous valid → sending high 11 cycles, low 1 cycle, repeating. No bit dropped or duplicated.
- Assert reset during bit 5 of a frame → next edge: sending=0, codeout=0, data_ready=1. A new payload 7'h55 then transmits 11'h52F from bit 10.
- Loopback through FSKEncoder/FSKDecoder/DecodeProcessor/HammingDecoder: all 128 payloads → hammingdecodeout equals data_in for every word.
- With HAMMING_ERR_INJECT_EN: data 7'h55, err_en=1, err_pos=6 → codeword=11'h50F. HammingDecoder still outputs 7'h55.
